// File: rtl/matmul_operand_loader_pkg.sv
// Shared types and constants for the matmul operand loader: geometry, widths
// and the loader FSM state encoding.
package matmul_pkg;

  localparam int DWIDTH   = 8;
  localparam int MAT_SIZE = 4;
  localparam int WORD_W   = MAT_SIZE * DWIDTH;
  localparam int AWIDTH   = 7;
  localparam int IDXW     = $clog2(MAT_SIZE * MAT_SIZE);
  localparam int KW       = $clog2(MAT_SIZE);

  localparam logic [AWIDTH-1:0] PAD_ADDR = 7'd127;
  localparam logic [IDXW-1:0]   LAST_IDX = '1;
  localparam logic [KW-1:0]     LAST_K   = '1;

  typedef enum logic [2:0] {
    IDLE,
    FILL_A,
    WRITE_A,
    FILL_B,
    WRITE_B,
    PAD,
    RUN,
    DONE
  } loader_state_t;

endpackage

// File: rtl/matmul_operand_loader_if.sv
// Stream, RAM-write and multiplier-handshake signals of the operand loader.
// master = the loader, slave = its environment (stream source, RAMs, multiplier).
interface matmul_operand_loader_if;
  import matmul_pkg::*;

  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              we_a;
  logic              we_b;
  logic [AWIDTH-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic              start_mat_mul;
  logic              done_mat_mul;

  modport master (
    input  in_valid, in_data, done_mat_mul,
    output in_ready, we_a, we_b, ram_addr, ram_wdata, start_mat_mul
  );

  modport slave (
    output in_valid, in_data, done_mat_mul,
    input  in_ready, we_a, we_b, ram_addr, ram_wdata, start_mat_mul
  );

endinterface

// File: rtl/matmul_operand_loader_pack_buf.sv
// 4x4 element buffer: one write port addressed by row-major index, plus two
// combinational word views (column k, row k) with element i in byte lane i.
module operand_pack_buf
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDXW-1:0]   wr_idx,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [KW-1:0]     col_k,
  output logic [WORD_W-1:0] col_word,
  input  logic [KW-1:0]     row_k,
  output logic [WORD_W-1:0] row_word
);

  logic [DWIDTH-1:0] mem_q [MAT_SIZE][MAT_SIZE];

  // NOTE: the buffer has no reset; every element is rewritten by a session
  // before any word that contains it is read out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx[IDXW-1:KW]][wr_idx[KW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    col_word = '0;
    row_word = '0;
    for (int i = 0; i < MAT_SIZE; i++) begin
      col_word[i*DWIDTH +: DWIDTH] = mem_q[i][col_k];
      row_word[i*DWIDTH +: DWIDTH] = mem_q[row_k][i];
    end
  end

endmodule

// File: rtl/matmul_operand_loader.sv
// Operand loader for the 4x4 multiplier: collects A then B from a byte stream,
// writes A by column and B by row, writes the zero pad word, then runs the multiply.
module matmul_operand_loader
  import matmul_pkg::*;
#(
  parameter logic [AWIDTH-1:0] A_BASE = '0,
  parameter logic [AWIDTH-1:0] B_BASE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  matmul_operand_loader_if.master bus,
  output logic                    busy,
  output logic                    load_done
);

  loader_state_t     state_q, state_d;
  logic [IDXW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;
  logic              we_a_q, we_a_d;
  logic              we_b_q, we_b_d;
  logic [AWIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              start_q, start_d;
  logic              load_done_q, load_done_d;

  logic              accept;
  logic [KW-1:0]     k_d;
  logic [WORD_W-1:0] col_word, row_word;

  assign accept = bus.in_valid && in_ready_q;
  assign k_d    = cnt_d[KW-1:0];

  operand_pack_buf u_buf (
    .clk      (clk),
    .wr_en    (accept),
    .wr_idx   (cnt_q),
    .wr_data  (bus.in_data),
    .col_k    (k_d),
    .col_word (col_word),
    .row_k    (k_d),
    .row_word (row_word)
  );

  // NOTE: every signal gets a default at the top so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (load_start) begin
        state_d = FILL_A;
        cnt_d   = '0;
      end
      FILL_A, FILL_B: if (bus.in_valid) begin
        if (cnt_q == LAST_IDX) begin
          state_d = (state_q == FILL_A) ? WRITE_A : WRITE_B;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE_A, WRITE_B: begin
        if (cnt_q[KW-1:0] == LAST_K) begin
          state_d = (state_q == WRITE_A) ? FILL_B : PAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PAD:  state_d = RUN;
      RUN:  if (bus.done_mat_mul) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned
  // with the state they belong to; no input reaches an output combinationally.
  always_comb begin
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == FILL_A) || (state_d == FILL_B);
    we_a_d      = (state_d == WRITE_A) || (state_d == PAD);
    we_b_d      = (state_d == WRITE_B) || (state_d == PAD);
    start_d     = (state_d == RUN);
    load_done_d = (state_d == DONE);
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    case (state_d)
      WRITE_A: begin
        ram_addr_d  = A_BASE + AWIDTH'(k_d);
        ram_wdata_d = col_word;
      end
      WRITE_B: begin
        ram_addr_d  = B_BASE + AWIDTH'(k_d);
        ram_wdata_d = row_word;
      end
      PAD:     ram_addr_d = PAD_ADDR;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      we_a_q      <= 1'b0;
      we_b_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      start_q     <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      we_a_q      <= we_a_d;
      we_b_q      <= we_b_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      start_q     <= start_d;
      load_done_q <= load_done_d;
    end
  end

  assign busy              = busy_q;
  assign load_done         = load_done_q;
  assign bus.in_ready      = in_ready_q;
  assign bus.we_a          = we_a_q;
  assign bus.we_b          = we_b_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_wdata     = ram_wdata_q;
  assign bus.start_mat_mul = start_q;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Self-checking bench for matmul_operand_loader: table of sessions with a
// RAM-write scoreboard, plus reset-mid-session and early-done sequences.
module tb_matmul_operand_loader;

  logic clk = 1'b0;
  logic reset;
  logic load_start;
  logic busy;
  logic load_done;

  matmul_operand_loader_if bif ();

  matmul_operand_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .bus        (bif.master),
    .busy       (busy),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we_a;
    logic        we_b;
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  a  [16];
    logic [7:0]  b  [16];
    logic [31:0] wa [4];
    logic [31:0] wb [4];
    bit          bp;
    bit          early;
  } vec_t;

  vec_t vecs [3];
  wr_t  exp_q [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_fill, t_wa0, t_wb0, t_pad, t_run;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAM-write scoreboard and in_ready invariant, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bif.we_a || bif.we_b) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ram_write", {bif.we_a, bif.we_b, bif.ram_addr, bif.ram_wdata}, 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("ram_write", 64'({bif.we_a, bif.we_b, bif.ram_addr, bif.ram_wdata}), 64'(e));
          if (e.we_a && !e.we_b && e.addr == 7'd0) t_wa0 = cyc;
          if (e.we_b && !e.we_a && e.addr == 7'd0) t_wb0 = cyc;
          if (e.we_a && e.we_b) t_pad = cyc;
        end
      end
      if (bif.in_ready) begin
        check("in_ready_outside_fill", {bif.we_a, bif.we_b, bif.start_mat_mul, load_done}, 64'd0);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, {busy, load_done, bif.in_ready, bif.we_a, bif.we_b, bif.start_mat_mul}, 64'd0);
    check({tag, "_addr"}, 64'(bif.ram_addr), 64'd0);
    check({tag, "_wdata"}, 64'(bif.ram_wdata), 64'd0);
  endtask

  task automatic feed_elem(input logic [7:0] d, input bit bp);
    bit rdy;
    int budget;
    if (bp) begin
      bif.in_valid = 1'b0;
      bif.in_data  = 8'hA5;
      tick();
    end
    bif.in_valid = 1'b1;
    bif.in_data  = d;
    budget = 0;
    do begin
      rdy = bif.in_ready;
      tick();
      budget++;
    end while (!rdy && budget < 50);
    if (!rdy) check("feed_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic push_session(input int v);
    for (int k = 0; k < 4; k++) exp_q.push_back('{1'b1, 1'b0, 7'(k), vecs[v].wa[k]});
    for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, 1'b1, 7'(k), vecs[v].wb[k]});
    exp_q.push_back('{1'b1, 1'b1, 7'd127, 32'd0});
  endtask

  task automatic run_vec(input int v);
    int n;
    bit bp;
    bp = vecs[v].bp;
    push_session(v);
    bif.done_mat_mul = vecs[v].early;
    t_wa0 = -1; t_wb0 = -1; t_pad = -1;
    pulse_load_start();
    check("fill_a_entry", {bif.in_ready, busy}, 64'b11);
    t_fill = cyc;
    for (int i = 0; i < 16; i++) feed_elem(vecs[v].a[i], bp);
    for (int i = 0; i < 16; i++) feed_elem(vecs[v].b[i], bp);
    bif.in_valid = 1'b0;
    n = 0;
    while (!bif.start_mat_mul && n < 200) begin
      tick();
      n++;
    end
    check("start_seen", 64'(bif.start_mat_mul), 64'd1);
    t_run = cyc;
    if (!bp) begin
      check("fill_a_to_write_a", 64'(t_wa0 - t_fill), 64'd16);
      check("write_a_to_write_b", 64'(t_wb0 - t_wa0), 64'd20);
      check("write_b_to_pad", 64'(t_pad - t_wb0), 64'd4);
      check("fill_a_to_run", 64'(t_run - t_fill), 64'd41);
    end
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    if (!vecs[v].early) begin
      for (int i = 0; i < 30; i++) begin
        load_start = (i == 10);
        check("start_held", {bif.start_mat_mul, load_done, busy}, 64'b101);
        tick();
      end
      load_start = 1'b0;
      bif.done_mat_mul = 1'b1;
      tick();
      bif.done_mat_mul = 1'b0;
    end else begin
      tick();
      bif.done_mat_mul = 1'b0;
    end
    check("done_cycle", {bif.start_mat_mul, load_done, busy}, 64'b011);
    tick();
    check("after_done", {bif.start_mat_mul, load_done, busy}, 64'b000);
    tick();
    check("no_queued_start", {busy, bif.in_ready}, 64'b00);
  endtask

  initial begin
    vecs[0].a  = '{8'd8, 8'd4, 8'd6, 8'd8, 8'd3, 8'd3, 8'd3, 8'd7,
                   8'd5, 8'd2, 8'd1, 8'd6, 8'd9, 8'd1, 8'd0, 8'd5};
    vecs[0].b  = '{8'd1, 8'd1, 8'd3, 8'd0, 8'd0, 8'd1, 8'd4, 8'd3,
                   8'd3, 8'd5, 8'd3, 8'd1, 8'd9, 8'd6, 8'd3, 8'd2};
    vecs[0].wa = '{32'h09050308, 32'h01020304, 32'h00010306, 32'h05060708};
    vecs[0].wb = '{32'h00030101, 32'h03040100, 32'h01030503, 32'h02030609};
    vecs[0].bp = 1'b0;
    vecs[0].early = 1'b0;
    vecs[1] = vecs[0];
    vecs[1].bp = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vecs[2].a[i] = 8'h10 + 8'(i);
      vecs[2].b[i] = 8'hE0 + 8'(i);
    end
    vecs[2].wa = '{32'h1C181410, 32'h1D191511, 32'h1E1A1612, 32'h1F1B1713};
    vecs[2].wb = '{32'hE3E2E1E0, 32'hE7E6E5E4, 32'hEBEAE9E8, 32'hEFEEEDEC};
    vecs[2].bp = 1'b0;
    vecs[2].early = 1'b1;

    reset = 1'b0;
    load_start = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_data = 8'h00;
    bif.done_mat_mul = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b1;
    mon_en = 1'b1;
    tick();
    check_idle_outputs("idle_after_reset");

    for (int v = 0; v < 3; v++) run_vec(v);

    // Reset while in FILL_B with 7 elements of B accepted.
    exp_q.push_back('{1'b1, 1'b0, 7'd0, vecs[0].wa[0]});
    exp_q.push_back('{1'b1, 1'b0, 7'd1, vecs[0].wa[1]});
    exp_q.push_back('{1'b1, 1'b0, 7'd2, vecs[0].wa[2]});
    exp_q.push_back('{1'b1, 1'b0, 7'd3, vecs[0].wa[3]});
    pulse_load_start();
    for (int i = 0; i < 16; i++) feed_elem(vecs[0].a[i], 1'b0);
    for (int i = 0; i < 7; i++) feed_elem(vecs[0].b[i], 1'b0);
    check("mid_fill_b", {bif.in_ready, busy}, 64'b11);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bif.in_valid = 1'b0;
    check_idle_outputs("reset_mid");
    check("sb_empty_before_reset", 64'(exp_q.size()), 64'd0);
    tick();
    check_idle_outputs("reset_mid_hold");

    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
